square_freq_counter: RTL and testbench
======================================

# square_freq_counter

Square-channel frequency timer for the APU. Holds the 11-bit period register written by the CPU through WR2/WR3 or by the sweep unit. Runs an 11-bit down-counter clocked by ACLK1 ticks. Generates the FLOAD/FCO pair that steps the square duty counter, so it is the producer of the stepping interface the duty unit consumes.

## Interface
- FREQ_W, 11, width of period register and counter
- CLK  in  1  core clock; all state updates on rising edge
- nRES  in  1  reset, synchronous, active-low
- ACLK1  in  1  APU tick enable; one-CLK-wide pulse per APU cycle
- WR2  in  1  write strobe, period low byte
- WR3  in  1  write strobe, period high bits (also length/duty-reset register)
- DB  in  8  CPU data bus, sampled on CLK edges where WR2/WR3=1
- SWEEP_LOAD  in  1  one-CLK pulse: load period from ADDOUT
- ADDOUT  in  FREQ_W  sweep adder result
- F  out  FREQ_W  current period register value, feeds sweep adder
- FCO  out  1  counter-is-zero carry
- FLOAD  out  1  reload pulse, one CLK wide, steps duty counter

## Operation
- Reset (nRES=0 at a CLK edge): F=0, counter=0, FLOAD=0, so FCO=1. Reset overrides every other input. Reset mid-count discards the count immediately.
- WR2=1: F[7:0] <= DB.
- WR3=1: F[10:8] <= DB[2:0]; DB[7:3] is ignored.
- SWEEP_LOAD=1: F <= ADDOUT.
- Simultaneous SWEEP_LOAD and CPU write: CPU write wins on the bits it writes; sweep supplies the remaining bits.
- Writes never touch the running counter. New F takes effect at the next reload.
- On a CLK edge with ACLK1=1:
  - counter==0: counter <= F (the value before any same-edge write) and FLOAD <= 1.
  - otherwise: counter <= counter-1 and FLOAD <= 0.
- On a CLK edge with ACLK1=0: counter holds and FLOAD <= 0.
- FCO = (counter==0), combinational from the counter register.
- Period: FLOAD fires once every F+1 ACLK1 ticks.
- F=0 boundary: FLOAD fires on every ACLK1 tick and FCO stays 1. This is legal; the sweep unit is responsible for muting.
- Arithmetic is unsigned FREQ_W-bit. Decrement never wraps because zero always reloads.

## Timing
- FLOAD is registered. It is high for exactly the CLK cycle following the ACLK1 edge that reloaded, and never longer than one CLK.
- FCO goes high in the CLK cycle after the counter reaches 0. It stays high until the next ACLK1 edge.
- Write-to-F latency: 1 CLK. F is visible on the output in the cycle after the write strobe.
- Write-to-period latency: up to the current count plus 1 ACLK1 tick.
- First ACLK1 tick after reset always reloads, because counter=0. FLOAD therefore pulses on the first tick.

## Structure
- Shared package apu_pkg:
  - FREQ_W=11
  - period register type freq_t
- Sub-module freq_downcounter: FREQ_W-bit down-counter with enable, zero detect and parallel reload.
- The top level holds the F register, the write and sweep muxing, and the FLOAD register.

## Test plan
- Reset: hold nRES=0 for 3 CLK with random inputs -> F=0, FLOAD=0, FCO=1. Release, first ACLK1 -> FLOAD pulse; with F=0 FLOAD then repeats every tick.
- Period: WR2 with DB=0x05, WR3 with DB=0x00, ACLK1 every 6 CLK -> after the first reload, FLOAD pulses every 6 ACLK1 ticks (36 CLK); FCO high one tick before each pulse.
- High bits: WR3 with DB=0xFB (F[10:8]=3), WR2 with DB=0xFF -> F=0x3FF; DB[7:3] ignored; FLOAD spacing 1024 ticks.
- Mid-count write: count running with F=10; at count=4, write WR2 with DB=2 -> current period completes at 11 ticks, next period is 3 ticks.
- Sweep vs CPU: same edge, SWEEP_LOAD with ADDOUT=0x7AA and WR2 with DB=0x11 -> F=0x711.
- Reset mid-operation: nRES=0 for one CLK at count=7 with FLOAD low -> counter=0, FCO=1, F=0; next ACLK1 -> FLOAD pulses.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU types and helpers used by the square-channel frequency timer.
package apu_pkg;

   localparam int FREQ_W = 11;

   typedef logic [FREQ_W-1:0] freq_t;

   // Sweep supplies the base value and the CPU write overrides only the bits it owns.
   function automatic freq_t next_period(
      input freq_t      cur,
      input logic       wr2,
      input logic       wr3,
      input logic       sweep_load,
      input logic [7:0] db,
      input freq_t      addout
   );
      freq_t nxt;
      nxt = sweep_load ? addout : cur;
      if (wr2) nxt[7:0] = db;
      if (wr3) nxt[FREQ_W-1:8] = db[FREQ_W-9:0];
      return nxt;
   endfunction

endpackage

// File: rtl/freq_downcounter.sv
// Down-counter with tick enable, zero detect and parallel reload on zero.
module freq_downcounter
   import apu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [FREQ_W-1:0] load_val,
   output logic [FREQ_W-1:0] count,
   output logic              zero
);

   assign zero = (count == '0);

   // Zero always reloads, so the decrement can never wrap.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (en)
         count <= zero ? load_val : count - 1'b1;
   end

endmodule

// File: rtl/square_freq_counter.sv
// Square-channel frequency timer: period register, write/sweep muxing and FLOAD pulse.
module square_freq_counter
   import apu_pkg::*;
(
   input  logic              CLK,
   input  logic              nRES,
   input  logic              ACLK1,
   input  logic              WR2,
   input  logic              WR3,
   input  logic [7:0]        DB,
   input  logic              SWEEP_LOAD,
   input  logic [FREQ_W-1:0] ADDOUT,
   output logic [FREQ_W-1:0] F,
   output logic              FCO,
   output logic              FLOAD
);

   logic [FREQ_W-1:0] count;
   logic              zero;

   always_ff @(posedge CLK) begin
      if (!nRES)
         F <= '0;
      else
         F <= next_period(F, WR2, WR3, SWEEP_LOAD, DB, ADDOUT);
   end

   // The counter reloads from the register value before any same-edge write.
   freq_downcounter u_cnt (
      .clk      (CLK),
      .rst_n    (nRES),
      .en       (ACLK1),
      .load_val (F),
      .count    (count),
      .zero     (zero)
   );

   always_ff @(posedge CLK) begin
      if (!nRES)
         FLOAD <= 1'b0;
      else
         FLOAD <= ACLK1 & zero;
   end

   assign FCO = zero;

endmodule

// File: tb/tb_square_freq_counter.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_square_freq_counter;

   logic        CLK = 1'b0;
   logic        nRES = 1'b0;
   logic        ACLK1 = 1'b0;
   logic        WR2 = 1'b0;
   logic        WR3 = 1'b0;
   logic [7:0]  DB = 8'h00;
   logic        SWEEP_LOAD = 1'b0;
   logic [10:0] ADDOUT = 11'h000;
   logic [10:0] F;
   logic        FCO;
   logic        FLOAD;

   square_freq_counter dut (
      .CLK(CLK), .nRES(nRES), .ACLK1(ACLK1), .WR2(WR2), .WR3(WR3), .DB(DB),
      .SWEEP_LOAD(SWEEP_LOAD), .ADDOUT(ADDOUT), .F(F), .FCO(FCO), .FLOAD(FLOAD)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int unsigned f;
      bit          fload;
      bit          fco;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;

   // Reference state: period value, ticks left before the next reload, pulse flag.
   int unsigned m_period = 0;
   int unsigned m_left = 0;
   bit          m_pulse = 0;

   function automatic void check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic model(input bit n, input bit a, input bit w2, input bit w3, input bit sl,
                        input int unsigned db, input int unsigned ad);
      exp_t e;
      int unsigned np;
      if (!n) begin
         m_period = 0; m_left = 0; m_pulse = 0;
      end else begin
         np = sl ? ad : m_period;
         if (w2) np = (np / 256) * 256 + db;
         if (w3) np = (db % 8) * 256 + (np % 256);
         m_pulse = 0;
         if (a) begin
            if (m_left == 0) begin
               m_left  = m_period;
               m_pulse = 1;
            end else begin
               m_left = m_left - 1;
            end
         end
         m_period = np;
      end
      e.f = m_period; e.fload = m_pulse; e.fco = (m_left == 0);
      sb.push_back(e);
   endtask

   task automatic cyc(input bit n, input bit a, input bit w2, input bit w3, input bit sl,
                      input logic [7:0] db, input logic [10:0] ad);
      @(negedge CLK);
      nRES = n; ACLK1 = a; WR2 = w2; WR3 = w3; SWEEP_LOAD = sl; DB = db; ADDOUT = ad;
      @(posedge CLK);
      model(n, a, w2, w3, sl, db, ad);
   endtask

   task automatic idle(input bit a);
      cyc(1, a, 0, 0, 0, 8'($urandom), 11'($urandom));
   endtask

   task automatic tick_every(input int n_clk);
      idle(1);
      for (int i = 1; i < n_clk; i++) idle(0);
   endtask

   // Monitor: one expectation per clock, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("F", F, e.f);
            check("FLOAD", FLOAD, e.fload);
            check("FCO", FCO, e.fco);
         end
      end
   end

   initial begin
      int guard;
      // Reset with random inputs
      for (int i = 0; i < 3; i++)
         cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 11'($urandom));
      #2;
      check("reset_F", F, 0);
      check("reset_FCO", FCO, 1);
      check("reset_FLOAD", FLOAD, 0);
      // F=0: every tick reloads
      for (int i = 0; i < 6; i++) tick_every(2);

      // Period F=5, tick every 6 CLK
      cyc(1, 0, 1, 0, 0, 8'h05, 11'h000);
      cyc(1, 0, 0, 1, 0, 8'h00, 11'h000);
      #2 check("period_F", F, 11'h005);
      for (int i = 0; i < 20; i++) tick_every(6);

      // High bits: DB[7:3] ignored
      cyc(1, 0, 0, 1, 0, 8'hFB, 11'h000);
      cyc(1, 0, 1, 0, 0, 8'hFF, 11'h000);
      #2 check("highbits_F", F, 11'h3FF);
      for (int i = 0; i < 2100; i++) idle(1);

      // Mid-count write
      cyc(1, 0, 1, 0, 0, 8'd10, 11'h000);
      cyc(1, 0, 0, 1, 0, 8'd0, 11'h000);
      guard = 0;
      while (m_left != 0 && guard < 2000) begin idle(1); guard++; end
      idle(1);
      guard = 0;
      while (m_left != 4 && guard < 40) begin idle(1); guard++; end
      check("midcount_reached", m_left, 4);
      cyc(1, 0, 1, 0, 0, 8'd2, 11'h000);
      for (int i = 0; i < 30; i++) tick_every(2);

      // Sweep vs CPU on the same edge
      cyc(1, 0, 1, 0, 1, 8'h11, 11'h7AA);
      #2 check("sweep_cpu_F", F, 11'h711);

      // Reset mid-operation at count=7
      cyc(1, 0, 1, 0, 0, 8'd20, 11'h000);
      guard = 0;
      while (m_left != 7 && guard < 4000) begin idle(1); guard++; end
      check("midreset_reached", m_left, 7);
      cyc(0, 0, 0, 0, 0, 8'h00, 11'h000);
      #2;
      check("midreset_FCO", FCO, 1);
      check("midreset_F", F, 0);
      idle(1);
      #2 check("midreset_first_FLOAD", FLOAD, 1);

      // Random traffic
      for (int i = 0; i < 4000; i++)
         cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 39) == 0), 8'($urandom & 32'h0F), 11'($urandom & 32'h1F));

      guard = 0;
      while (sb.size() != 0 && guard < 10) begin @(posedge CLK); guard++; end
      #2 check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
